// File: rtl/pwm_rpm_decoder.sv
// pwm_rpm_decoder: measures the high time of each period of an RPM-command PWM
// line and converts it back to rpm (high_cycles / CYCLES_PER_RPM, clamped to
// MAX_RPM). One result per period. A line stuck low or high is reported as
// signal loss with rpm 0 or MAX_RPM.
//
// Valid/ready note: the result interface is push-only. rpm_valid is a
// single-cycle pulse that marks a new rpm_measured/signal_lost pair. There is
// no back-pressure, so the consumer must take the value in that cycle.
// rpm_measured then holds until the next pulse.
module pwm_rpm_decoder #(
    parameter int unsigned CYCLES_PER_RPM = 50,
    parameter int unsigned MAX_RPM        = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [15:0] rpm_measured,
    output logic        rpm_valid,
    output logic        signal_lost,
    output logic        busy
);

    localparam logic [31:0] DIVISOR   = 32'(CYCLES_PER_RPM);
    localparam logic [31:0] MAX_C     = 32'(MAX_RPM);
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Input conditioning: two synchronizer flops, then s and its previous value.
    logic sync1_q, sync2_q, s_q, s_prev_q;
    logic rise;

    // Measurement counters and arming flag.
    logic [31:0] period_cnt_q, period_cnt_d;
    logic [31:0] high_cnt_q, high_cnt_d;
    logic        armed_q, armed_d;
    logic        timeout;

    // Restoring divider state.
    state_e      state_q, state_d;
    logic [4:0]  iter_q, iter_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_shift;

    // Registered outputs.
    logic [15:0] rpm_q, rpm_d;
    logic        valid_q, valid_d;
    logic        lost_q, lost_d;

    assign rise = s_q & ~s_prev_q;
    // period_cnt would reach TIMEOUT_CYCLES this cycle. A rise in the same
    // cycle takes priority, so it suppresses the timeout.
    assign timeout = ~rise && (period_cnt_q >= TIMEOUT_C - 32'd1);
    // Shift in the next dividend bit. The extra top bit keeps the
    // trial-subtract compare exact.
    assign rem_shift = {rem_q, quo_q[31]};

    assign rpm_measured = rpm_q;
    assign rpm_valid    = valid_q;
    assign signal_lost  = lost_q;
    assign busy         = (state_q == S_DIV) || (state_q == S_DONE);

    // Synchronize the asynchronous pin and keep one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= pwm_in;
            sync2_q  <= sync1_q;
            s_q      <= sync2_q;
            s_prev_q <= s_q;
        end
    end

    // Next-state logic for the divider FSM, the counters, arming and the outputs.
    always_comb begin
        state_d      = state_q;
        iter_d       = iter_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        armed_d      = armed_q;
        rpm_d        = rpm_q;
        valid_d      = 1'b0;
        lost_d       = lost_q;
        period_cnt_d = (period_cnt_q >= TIMEOUT_C) ? TIMEOUT_C : period_cnt_q + 32'd1;
        high_cnt_d   = (s_q && (high_cnt_q != '1)) ? high_cnt_q + 32'd1 : high_cnt_q;

        case (state_q)
            S_DIV: begin
                if (rem_shift >= {1'b0, DIVISOR}) begin
                    rem_d = 32'(rem_shift - {1'b0, DIVISOR});
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (iter_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    iter_d = iter_q + 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                valid_d = 1'b1;
                lost_d  = 1'b0;
                rpm_d   = (quo_q > MAX_C) ? MAX_C[15:0] : quo_q[15:0];
            end
            default: ;
        endcase

        if (rise) begin
            // The edge cycle itself counts as the first high cycle of the new period.
            period_cnt_d = 32'd1;
            high_cnt_d   = 32'd1;
            if (!armed_q) begin
                armed_d = 1'b1;
            end else if (state_q == S_IDLE) begin
                // high_cnt_q still holds the finished period's high time.
                rem_d   = '0;
                quo_d   = high_cnt_q;
                iter_d  = '0;
                state_d = S_DIV;
            end
            // A rise while the divider is busy drops that period's measurement.
        end else if (timeout) begin
            // Timeout overrides any divide in flight, including its DONE cycle.
            period_cnt_d = '0;
            armed_d      = 1'b0;
            state_d      = S_IDLE;
            valid_d      = 1'b1;
            lost_d       = 1'b1;
            rpm_d        = s_q ? MAX_C[15:0] : 16'd0;
        end
    end

    // State register for the counters, the divider FSM and the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            armed_q      <= 1'b0;
            state_q      <= S_IDLE;
            iter_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            rpm_q        <= '0;
            valid_q      <= 1'b0;
            lost_q       <= 1'b1;
        end else begin
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            iter_q       <= iter_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            rpm_q        <= rpm_d;
            valid_q      <= valid_d;
            lost_q       <= lost_d;
        end
    end

endmodule

// File: tb/tb_pwm_rpm_decoder.sv
// Testbench for pwm_rpm_decoder. The scale is reduced so a full period is 500
// clocks and the timeout is 1000 clocks. A negedge monitor compares every
// rpm_valid pulse against the queue of expected {signal_lost, rpm} results.
module tb_pwm_rpm_decoder;

    localparam int CPR  = 50;
    localparam int MAXR = 10;
    localparam int TO   = 1000;
    localparam int LAT  = 37;   // 3 sync cycles + 34 rise-to-valid cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [15:0] rpm_measured;
    logic        rpm_valid;
    logic        signal_lost;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;

    logic [16:0] exp_q[$];
    int          vcyc_q[$];
    logic [16:0] exp_v;

    pwm_rpm_decoder #(
        .CYCLES_PER_RPM(CPR),
        .MAX_RPM(MAXR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .rpm_measured(rpm_measured),
        .rpm_valid(rpm_valid),
        .signal_lost(signal_lost),
        .busy(busy)
    );

    // Clock and cycle counter.
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every result pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rpm_valid) begin
            vcyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got rpm=%0d lost=%0b at cycle %0d, none expected",
                         rpm_measured, signal_lost, cyc);
            end else begin
                exp_v = exp_q.pop_front();
                if ({signal_lost, rpm_measured} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got rpm=%0d lost=%0b, expected rpm=%0d lost=%0b",
                             rpm_measured, signal_lost, exp_v[15:0], exp_v[16]);
                end
            end
        end
    end

    function automatic logic [15:0] exp_rpm(input int h);
        int q;
        q = h / CPR;
        if (q > MAXR) q = MAXR;
        return 16'(q);
    endfunction

    task automatic do_reset();
        pwm_in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        vcyc_q.delete();
    endtask

    task automatic level(input logic v, input int n);
        if (v && !pwm_in) rise_cyc = cyc;
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    // One period. When push is set, its result is expected at the next rise.
    task automatic period(input int h, input int l, input bit push);
        if (push) exp_q.push_back({1'b0, exp_rpm(h)});
        level(1'b1, h);
        level(1'b0, l);
    endtask

    // Closing rise that captures the last period, followed by idle time.
    task automatic finish_edge();
        level(1'b1, 5);
        level(1'b0, 60);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (rpm_measured !== 16'd0) begin errors++; $display("FAIL reset_rpm: got %0d, expected 0", rpm_measured); end
        if (rpm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", rpm_valid); end
        if (signal_lost !== 1'b1) begin errors++; $display("FAIL reset_lost: got %b, expected 1", signal_lost); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_nominal();
        do_reset();
        level(1'b0, 5);
        exp_q.push_back({1'b0, exp_rpm(250)});
        level(1'b1, 250);
        checks++;
        if (signal_lost !== 1'b1) begin
            errors++;
            $display("FAIL arm_lost: got %b, expected 1 while arming", signal_lost);
        end
        level(1'b0, 251);
        period(250, 251, 1);
        period(250, 251, 1);
        finish_edge();
        wait_drain(100);
        checks++;
        if (signal_lost !== 1'b0) begin
            errors++;
            $display("FAIL nominal_lost: got %b, expected 0", signal_lost);
        end
    endtask

    task automatic test_floor();
        int h, l;
        do_reset();
        period(50, 449, 1);
        period(99, 400, 1);
        period(100, 399, 1);
        for (int i = 0; i < 5; i++) begin
            h = $urandom_range(1, 500);
            l = $urandom_range(40, 400);
            period(h, l, 1);
        end
        finish_edge();
        wait_drain(100);
    endtask

    task automatic test_clamp();
        do_reset();
        period(1, 40, 1);
        period(500, 1, 1);
        period(600, 10, 1);
        finish_edge();
        wait_drain(100);
    endtask

    task automatic test_timeout(input logic stuck);
        int c;
        do_reset();
        period(200, 300, 1);
        exp_q.push_back({1'b1, stuck ? 16'(MAXR) : 16'd0});
        exp_q.push_back({1'b1, stuck ? 16'(MAXR) : 16'd0});
        if (stuck) begin
            level(1'b1, 2100);
        end else begin
            level(1'b1, 5);
            level(1'b0, 2100);
        end
        c = rise_cyc;
        wait_drain(10);
        checks++;
        if (vcyc_q.size() != 3) begin
            errors++;
            $display("FAIL timeout_count: got %0d pulses, expected 3", vcyc_q.size());
        end else begin
            checks++;
            if (vcyc_q[1] - c != TO + 3) begin
                errors++;
                $display("FAIL timeout_first: got %0d cycles after rise, expected %0d", vcyc_q[1] - c, TO + 3);
            end
            if (vcyc_q[2] - vcyc_q[1] != TO) begin
                errors++;
                $display("FAIL timeout_repeat: got interval %0d, expected %0d", vcyc_q[2] - vcyc_q[1], TO);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        period(100, 300, 1);
        c = cyc;
        level(1'b1, 5);
        level(1'b0, 15);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_div: got %b, expected 1", busy);
        end
        period(150, 300, 1);
        finish_edge();
        wait_drain(100);
        checks++;
        if (vcyc_q.size() == 0) begin
            errors++;
            $display("FAIL latency: got no pulse, expected one");
        end else if (vcyc_q[0] - c != LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d", vcyc_q[0] - c, LAT);
        end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        period(100, 300, 1);
        period(150, 300, 0);
        level(1'b1, 5);
        level(1'b0, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (rpm_measured !== 16'd0) begin errors++; $display("FAIL midrst_rpm: got %0d, expected 0", rpm_measured); end
        if (rpm_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, expected 0", rpm_valid); end
        if (signal_lost !== 1'b1) begin errors++; $display("FAIL midrst_lost: got %b, expected 1", signal_lost); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        vcyc_q.delete();
        level(1'b0, 60);
        exp_q.push_back({1'b0, exp_rpm(120)});
        level(1'b1, 120);
        checks++;
        if (signal_lost !== 1'b1 || vcyc_q.size() != 0) begin
            errors++;
            $display("FAIL rearm: got lost=%b pulses=%0d, expected lost=1 pulses=0",
                     signal_lost, vcyc_q.size());
        end
        level(1'b0, 300);
        finish_edge();
        wait_drain(100);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_floor();
        test_clamp();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
